// File: rtl/branch_predictor_pkg.sv
// Shared sizes and 2-bit counter encodings for the branch predictor slice.
package branch_predictor_pkg;

  localparam int SIZE_ADDR = 16;
  localparam int HBIT_ADDR = SIZE_ADDR - 1;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_e;

  localparam logic [1:0] BP_CTR_INIT  = BP_WNT;
  localparam logic [1:0] BP_CTR_ALLOC = BP_WT;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// bp_sat_ctr2: combinational next value of a 2-bit saturating direction counter.
import branch_predictor_pkg::*;

module bp_sat_ctr2 (
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // Step one state toward the resolved direction, holding at either end.
  always_comb begin
    ctr_next = ctr;
    case (ctr)
      BP_SNT:  ctr_next = taken ? BP_WNT : BP_SNT;
      BP_WNT:  ctr_next = taken ? BP_WT  : BP_SNT;
      BP_WT:   ctr_next = taken ? BP_ST  : BP_WNT;
      BP_ST:   ctr_next = taken ? BP_ST  : BP_WT;
      default: ctr_next = BP_CTR_INIT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; combinational lookup, registered training.
// Optional statistics counters are enabled by defining BRANCH_PRED_STATS_EN.
import branch_predictor_pkg::*;

module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int IDX_BITS = 4,
  parameter int STAT_W   = 16
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst_n,
  input  logic                 iw_fetch_valid,
  input  logic [SIZE_ADDR-1:0] iw_fetch_pc,
  output logic                 ow_pred_taken,
  output logic [SIZE_ADDR-1:0] ow_pred_pc,
  input  logic                 iw_update,
  input  logic [SIZE_ADDR-1:0] iw_update_pc,
  input  logic                 iw_update_taken,
  input  logic [SIZE_ADDR-1:0] iw_update_target
`ifdef BRANCH_PRED_STATS_EN
  ,
  input  logic                 iw_flush,
  output logic [STAT_W-1:0]    ow_stat_lookups,
  output logic [STAT_W-1:0]    ow_stat_mispred
`endif
);

  localparam int TAG_W = HBIT_ADDR + 1 - IDX_BITS;

  if (TAG_W < 1) begin : g_bad_tag
    $error("branch_predictor: tag width must be at least one bit");
  end

  logic                 valid_r  [ENTRIES];
  logic [TAG_W-1:0]     tag_r    [ENTRIES];
  logic [SIZE_ADDR-1:0] target_r [ENTRIES];
  logic [1:0]           ctr_r    [ENTRIES];

  logic [IDX_BITS-1:0]  fetch_idx_s;
  logic [TAG_W-1:0]     fetch_tag_s;
  logic                 fetch_hit_s;
  logic [IDX_BITS-1:0]  upd_idx_s;
  logic [TAG_W-1:0]     upd_tag_s;
  logic                 upd_hit_s;
  logic [1:0]           upd_ctr_next_s;

  assign fetch_idx_s = iw_fetch_pc[IDX_BITS-1:0];
  assign fetch_tag_s = iw_fetch_pc[HBIT_ADDR:IDX_BITS];
  assign upd_idx_s   = iw_update_pc[IDX_BITS-1:0];
  assign upd_tag_s   = iw_update_pc[HBIT_ADDR:IDX_BITS];

  // Lookup reads pre-update table state; no bypass from a same-cycle update.
  always_comb begin
    fetch_hit_s   = valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_tag_s);
    ow_pred_taken = fetch_hit_s && ctr_r[fetch_idx_s][1];
    if (ow_pred_taken) begin
      ow_pred_pc = target_r[fetch_idx_s];
    end else begin
      ow_pred_pc = iw_fetch_pc + {{(SIZE_ADDR-1){1'b0}}, 1'b1};
    end
  end

  assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);

  bp_sat_ctr2 u_sat_ctr (
    .ctr      (ctr_r[upd_idx_s]),
    .taken    (iw_update_taken),
    .ctr_next (upd_ctr_next_s)
  );

  // Table training: train on hit, allocate on taken miss, ignore not-taken miss.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {SIZE_ADDR{1'b0}};
        ctr_r[i]    <= BP_CTR_INIT;
      end
    end else if (iw_update) begin
      if (upd_hit_s) begin
        ctr_r[upd_idx_s] <= upd_ctr_next_s;
        if (iw_update_taken) begin
          target_r[upd_idx_s] <= iw_update_target;
        end
      end else if (iw_update_taken) begin
        valid_r[upd_idx_s]  <= 1'b1;
        tag_r[upd_idx_s]    <= upd_tag_s;
        target_r[upd_idx_s] <= iw_update_target;
        ctr_r[upd_idx_s]    <= BP_CTR_ALLOC;
      end
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  logic [STAT_W-1:0] lookups_r;
  logic [STAT_W-1:0] mispred_r;

  // Saturating event counters for valid fetches and flushed updates.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      lookups_r <= {STAT_W{1'b0}};
      mispred_r <= {STAT_W{1'b0}};
    end else begin
      if (iw_fetch_valid && (lookups_r != {STAT_W{1'b1}})) begin
        lookups_r <= lookups_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end
      if (iw_update && iw_flush && (mispred_r != {STAT_W{1'b1}})) begin
        mispred_r <= mispred_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign ow_stat_lookups = lookups_r;
  assign ow_stat_mispred = mispred_r;
`else
  logic unused_fetch_valid_s;
  assign unused_fetch_valid_s = iw_fetch_valid;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, 16-bit PCs).
// Define BRANCH_PRED_STATS_EN to also exercise the statistics counters.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic [15:0] pred_pc;
  logic        update;
  logic [15:0] update_pc;
  logic        update_taken;
  logic [15:0] update_target;
`ifdef BRANCH_PRED_STATS_EN
  logic        flush;
  logic [15:0] stat_lookups;
  logic [15:0] stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  branch_predictor #(.ENTRIES(16), .IDX_BITS(4), .STAT_W(16)) dut (
    .iw_clk           (clk),
    .iw_rst_n         (rst_n),
    .iw_fetch_valid   (fetch_valid),
    .iw_fetch_pc      (fetch_pc),
    .ow_pred_taken    (pred_taken),
    .ow_pred_pc       (pred_pc),
    .iw_update        (update),
    .iw_update_pc     (update_pc),
    .iw_update_taken  (update_taken),
    .iw_update_target (update_target)
`ifdef BRANCH_PRED_STATS_EN
    ,
    .iw_flush         (flush),
    .ow_stat_lookups  (stat_lookups),
    .ow_stat_mispred  (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One training strobe across a single rising edge.
  task automatic train(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
    update        = 1'b1;
    update_pc     = pc;
    update_taken  = tk;
    update_target = tgt;
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  task automatic expect_pred(input string tag, input logic [15:0] pc,
                             input logic exp_tk, input logic [15:0] exp_pc);
    fetch_pc = pc;
    #1;
    check_value({tag, "_taken"}, {15'd0, pred_taken}, {15'd0, exp_tk});
    check_value({tag, "_pc"}, pred_pc, exp_pc);
  endtask

  initial begin
    rst_n         = 1'b0;
    fetch_valid   = 1'b0;
    fetch_pc      = 16'h0010;
    update        = 1'b0;
    update_pc     = 16'h0000;
    update_taken  = 1'b0;
    update_target = 16'h0000;
`ifdef BRANCH_PRED_STATS_EN
    flush         = 1'b0;
`endif
    #2;
    expect_pred("reset", 16'h0010, 1'b0, 16'h0011);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Allocate, then weaken to not-taken.
    train(16'h0010, 1'b1, 16'h0040);
    expect_pred("alloc", 16'h0010, 1'b1, 16'h0040);
    train(16'h0010, 1'b0, 16'h0000);
    expect_pred("weaken", 16'h0010, 1'b0, 16'h0011);

    // Aliasing on index 0 with a different tag, then replacement.
    train(16'h0010, 1'b1, 16'h0040);
    expect_pred("retrain", 16'h0010, 1'b1, 16'h0040);
    expect_pred("alias_miss", 16'h0020, 1'b0, 16'h0021);
    train(16'h0020, 1'b1, 16'h0080);
    expect_pred("replace_new", 16'h0020, 1'b1, 16'h0080);
    expect_pred("replace_old", 16'h0010, 1'b0, 16'h0011);

    // Upper saturation: alloc(10) -> 11 -> 11; one not-taken -> 10, target kept.
    train(16'h0010, 1'b1, 16'h0040);
    train(16'h0010, 1'b1, 16'h0040);
    train(16'h0010, 1'b1, 16'h0040);
    expect_pred("sat_hi", 16'h0010, 1'b1, 16'h0040);
    train(16'h0010, 1'b0, 16'h0077);
    expect_pred("sat_hi_dec", 16'h0010, 1'b1, 16'h0040);
    train(16'h0010, 1'b0, 16'h0000);
    expect_pred("dec_to_wnt", 16'h0010, 1'b0, 16'h0011);

    // Lower saturation: drive to 00 and beyond, one taken must land at 01.
    for (int i = 0; i < 3; i++) train(16'h0010, 1'b0, 16'h0000);
    train(16'h0010, 1'b1, 16'h0040);
    expect_pred("sat_lo", 16'h0010, 1'b0, 16'h0011);

    // Same-cycle lookup and update: pre-update state before the edge.
    fetch_pc      = 16'h0046;
    update        = 1'b1;
    update_pc     = 16'h0046;
    update_taken  = 1'b1;
    update_target = 16'h0011;
    #1;
    check_value("nobypass_taken", {15'd0, pred_taken}, 16'h0000);
    check_value("nobypass_pc", pred_pc, 16'h0047);
    @(posedge clk);
    #1;
    update = 1'b0;
    expect_pred("after_edge", 16'h0046, 1'b1, 16'h0011);

    // Not-taken miss on an occupied index must not replace it.
    train(16'h0086, 1'b0, 16'h0123);
    expect_pred("nt_miss_keep", 16'h0046, 1'b1, 16'h0011);
    expect_pred("nt_miss_new", 16'h0086, 1'b0, 16'h0087);

    expect_pred("pc_wrap", 16'hFFFF, 1'b0, 16'h0000);

    // Async reset mid-run with an update held: table cleared, update dropped.
    update        = 1'b1;
    update_pc     = 16'h0050;
    update_taken  = 1'b1;
    update_target = 16'h0222;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    update = 1'b0;
    rst_n  = 1'b1;
    expect_pred("rst_clr_46", 16'h0046, 1'b0, 16'h0047);
    expect_pred("rst_clr_20", 16'h0020, 1'b0, 16'h0021);
    expect_pred("rst_drop_50", 16'h0050, 1'b0, 16'h0051);

`ifdef BRANCH_PRED_STATS_EN
    @(negedge clk);
    check_value("stat_lookups_0", stat_lookups, 16'd0);
    fetch_valid = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    fetch_valid = 1'b0;
    flush = 1'b1;
    train(16'h0030, 1'b1, 16'h0300);
    train(16'h0031, 1'b0, 16'h0000);
    flush = 1'b0;
    train(16'h0032, 1'b1, 16'h0301);
    check_value("stat_lookups", stat_lookups, 16'd5);
    check_value("stat_mispred", stat_mispred, 16'd2);
    rst_n = 1'b0;
    #1;
    check_value("stat_rst_lookups", stat_lookups, 16'd0);
    check_value("stat_rst_mispred", stat_mispred, 16'd0);
    expect_pred("stat_rst_table", 16'h0030, 1'b0, 16'h0031);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
